vigenere_deciph_stream: RTL and testbench
=========================================

// Module: vigenere_deciph_stream
// PURPOSE
//  Receive-side decipher stage: consumes the uppercase ciphertext bytes from the Vigenere encrypt stage and recovers lowercase plaintext.
//  Regenerates the same LFSR keystream in lockstep: one key step per accepted symbol.
//  Valid/ready on both sides; 2-stage pipeline (capture, decipher) with full-throughput backpressure.
// PARAMETERS
//  SEED      32'hACE1_1357  LFSR state after reset; also replaces an all-zero key_seed on load
//  TAPS      32'h8020_0003  Galois LFSR feedback mask (must match the encrypt-side keystream)
//  ERR_CNT_W 16             width of err_cnt (used only when VIG_DEC_ERRCNT_EN is defined)
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   synchronous, active-high reset
//  key_load  in   1   load key_seed into LFSR and flush pipeline
//  key_seed  in   32  new LFSR state
//  s_valid   in   1   ciphertext byte valid
//  s_ready   out  1   stage can accept byte
//  s_data    in   8   ciphertext byte (ASCII 'A'..'Z' expected)
//  m_valid   out  1   plaintext byte valid
//  m_ready   in   1   downstream accepts byte
//  m_data    out  8   plaintext byte ('a'..'z') or passthrough on error
//  m_err     out  1   m_data is a passthrough non-letter (qualified by m_valid)
//  err_cnt   out  ERR_CNT_W  saturating error count (only with VIG_DEC_ERRCNT_EN)
// BEHAVIOUR
//  - Reset: lfsr=SEED; s1_valid=0; m_valid=0; m_data=0; m_err=0; err_cnt=0. s_ready=0 during rst, otherwise combinational.
//  - Transfer on a side = valid & ready in the same cycle. m_data/m_err hold stable while m_valid & !m_ready.
//  - Key k = lfsr[27:23] % 26, taken from the current state; the LFSR advances one step per accepted input (incl. error bytes).
//  - Stage 1 captures {s_data, k}. Stage 2 computes the output register.
//  - Latency: accept at cycle N -> m_valid at N+2. Sustained 1 byte/clk when m_ready=1.
//  - s_ready = !s1_valid | s2_free, where s2_free = !m_valid | m_ready. No combinational path from s_valid to s_ready.
//  - Decipher: if 65<=c<=90: p = ((c-65) + 26 - k) % 26 + 97; use 6-bit intermediate, no underflow; m_err=0.
//  - Otherwise: m_data=c, m_err=1.
//  - Step: lfsr_next = lfsr[0] ? (lfsr>>1) ^ TAPS : lfsr>>1.
//  - key_load (rst wins over it): lfsr <= (key_seed==0 ? SEED : key_seed); s1_valid and m_valid cleared; s_ready=0 that cycle;
//    any s_valid that cycle is not accepted. First key after load comes from the loaded state.
//  - Backpressure: when m_valid & !m_ready and s1_valid, stage 1 holds and s_ready=0; the LFSR does not advance.
//  - Reset mid-stream: in-flight bytes discarded, no partial output. err_cnt cleared.
// CONFIGURATION
//  VIG_DEC_ERRCNT_EN defined:
//   - err_cnt port exists.
//   - Increments on each output transfer with m_err=1.
//   - Saturates at all-ones; cleared by rst and key_load.
//  Undefined:
//   - err_cnt port and counter are absent.
//   - m_err behaviour is unchanged.
// STRUCTURE
//  vig_pkg (shared include): ASCII_UC_A=65, ASCII_UC_Z=90, ASCII_LC_A=97, ALPHA=26, KEY_MSB=27, KEY_LSB=23, default TAPS/SEED.
//  Sub-module vig_keystream: 32-bit LFSR with load/step/seed-zero guard and key output.
//   - Shared with the encrypt side so both ends use one keystream definition.
// TESTING
//  1 Load 0x0800_0000 (k=16), send 'Q'(0x51), m_ready=1 -> m_data 'a'(0x61) at accept+2, m_err=0.
//  2 Load 0x0080_0000 (k=1), send 'A' -> 'z'(0x7A); checks mod-26 wrap below zero.
//  3 Load 0x0800_0000, send '5'(0x35) -> m_data 0x35, m_err=1; next byte uses the advanced key per reference model
//    (err_cnt=1 when VIG_DEC_ERRCNT_EN is defined).
//  4 Stream of 64 random 'A'..'Z' with random m_ready, compared against a model of the encrypt stage -> exact plaintext order;
//    no drops or duplicates; m_data stable while stalled.
//  5 Assert key_load with s_valid=1 and a full pipeline -> s_ready=0, m_valid=0 next cycle;
//    next output uses the new seed's first key.
//  6 Assert rst mid-stream for 1 cycle -> all outputs at reset values; after release the keystream restarts from SEED.

Source files
------------

// File: rtl/vig_pkg.sv
// Shared constants and helpers for the Vigenere encrypt/decrypt pair.
// Contents: ASCII bounds, alphabet size, key slice position, default
// LFSR seed/taps, the stage-1 capture struct and a mod-26 reducer.
package vig_pkg;
  localparam logic [7:0]  ASCII_UC_A = 8'd65;
  localparam logic [7:0]  ASCII_UC_Z = 8'd90;
  localparam logic [7:0]  ASCII_LC_A = 8'd97;
  localparam logic [5:0]  ALPHA      = 6'd26;
  localparam int          KEY_MSB    = 27;
  localparam int          KEY_LSB    = 23;
  localparam logic [31:0] DEF_SEED   = 32'hACE1_1357;
  localparam logic [31:0] DEF_TAPS   = 32'h8020_0003;

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] key;
  } s1_t;

  // A 5-bit slice is at most 31, so one conditional subtract reduces mod 26.
  function automatic logic [4:0] mod26_5(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction
endpackage

// File: rtl/vig_keystream.sv
// 32-bit Galois LFSR keystream shared by the encrypt and decrypt stages.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (state <= SEED)
//   load/seed : load a new state; an all-zero seed is replaced by SEED
//   step      : advance one step (ignored while load is high)
//   key       : current key, state[KEY_MSB:KEY_LSB] mod 26
module vig_keystream
  import vig_pkg::*;
#(
  parameter logic [31:0] SEED = DEF_SEED,
  parameter logic [31:0] TAPS = DEF_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [4:0]  key
);
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = (seed == 32'd0) ? SEED : seed;
    else if (step) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign key = mod26_5(lfsr_q[KEY_MSB:KEY_LSB]);
endmodule

// File: rtl/vigenere_deciph_stream.sv
// Receive-side Vigenere decipher: uppercase ciphertext in, lowercase
// plaintext out. Two-stage valid/ready pipeline (capture, decipher) with
// full-throughput backpressure; the keystream steps once per accepted byte.
// Optional feature: define VIG_DEC_ERRCNT_EN to add the saturating err_cnt.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   key_load, key_seed : reload keystream and flush the pipeline
//   s_valid/s_ready/s_data        : ciphertext input handshake
//   m_valid/m_ready/m_data/m_err  : plaintext output; m_err flags passthrough
//   err_cnt            : count of error bytes delivered (optional)
module vigenere_deciph_stream
  import vig_pkg::*;
#(
  parameter logic [31:0] SEED      = DEF_SEED,
  parameter logic [31:0] TAPS      = DEF_TAPS,
  parameter int          ERR_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [31:0] key_seed,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_err
`ifdef VIG_DEC_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
  logic       s1_valid_q, s1_valid_d;
  s1_t        s1_q, s1_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_err_q, m_err_d;
  logic       s2_free, accept;
  logic [4:0] key;
  logic [4:0] off;
  logic [5:0] sum, red;
  logic       is_uc;
  logic [7:0] dec_data;

  // s_ready depends only on state and control inputs, never on s_valid.
  assign s2_free = !m_valid_q || m_ready;
  assign s_ready = !rst && !key_load && (!s1_valid_q || s2_free);
  assign accept  = s_valid && s_ready;

  vig_keystream #(.SEED(SEED), .TAPS(TAPS)) u_ks (
    .clk  (clk),
    .rst  (rst),
    .load (key_load),
    .seed (key_seed),
    .step (accept),
    .key  (key)
  );

  // (c-65) + 26 - k stays within 1..51, so 6 bits never underflow.
  always_comb begin
    is_uc    = (s1_q.data >= ASCII_UC_A) && (s1_q.data <= ASCII_UC_Z);
    off      = 5'(s1_q.data - ASCII_UC_A);
    sum      = {1'b0, off} + ALPHA - {1'b0, s1_q.key};
    red      = (sum >= ALPHA) ? sum - ALPHA : sum;
    dec_data = is_uc ? ({2'b00, red} + ASCII_LC_A) : s1_q.data;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_err_d    = m_err_q;
    if (s2_free) begin
      m_valid_d  = s1_valid_q;
      s1_valid_d = 1'b0;
      if (s1_valid_q) begin
        m_data_d = dec_data;
        m_err_d  = !is_uc;
      end
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = '{data: s_data, key: key};
    end
    if (key_load) begin
      s1_valid_d = 1'b0;
      m_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'd0;
      m_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_err   = m_err_q;

`ifdef VIG_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (key_load)
      err_cnt_d = '0;
    else if (m_valid_q && m_ready && m_err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_vigenere_deciph_stream.sv
// Directed bench for vigenere_deciph_stream: reset, key/wrap cases, error
// passthrough, random-ready stream against an encrypt-side model, key_load
// flush and mid-stream reset.
module tb_vigenere_deciph_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [31:0] key_seed;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_err;
`ifdef VIG_DEC_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] outq[$];
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_out   = '0;

  always #5 clk = ~clk;

  vigenere_deciph_stream dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_seed (key_seed),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_err    (m_err)
`ifdef VIG_DEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent encrypt-side keystream model.
  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  function automatic int m_key(input logic [31:0] s);
    return int'(s[27:23]) % 26;
  endfunction

  // Output monitor, sampled mid-cycle: records transfers and checks hold.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {23'd0, m_err, m_data}, {23'd0, prev_out});
    end
    if (m_valid && m_ready) outq.push_back({m_err, m_data});
    prev_stall <= m_valid && !m_ready && !rst && !key_load;
    prev_out   <= {m_err, m_data};
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [31:0] seed);
    key_load = 1'b1; key_seed = seed;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1; s_data = b;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) chk("send_timeout", 32'd1, 32'd0);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic exp_err, input logic [7:0] exp_data);
    int n = 0;
    while (outq.size() == 0 && n < 50) begin tick(); n++; end
    if (outq.size() == 0) chk({tag, "_timeout"}, 32'd1, 32'd0);
    else chk(tag, {23'd0, outq.pop_front()}, {23'd0, exp_err, exp_data});
  endtask

  initial begin
    logic [31:0] st;
    logic [7:0]  exp_q[$];
    logic        done;
    rst = 1'b1; key_load = 1'b0; key_seed = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_m_err", {31'd0, m_err}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // 1: k=16, 'Q' -> 'a', latency 2
    load_key(32'h0800_0000);
    send(8'h51);
    chk("t1_lat1", {31'd0, m_valid}, 32'd0);
    tick();
    chk("t1_lat2", {31'd0, m_valid}, 32'd1);
    chk("t1_data", {23'd0, m_err, m_data}, {23'd0, 1'b0, 8'h61});
    tick(); outq.delete();

    // 2: k=1, 'A' -> 'z'
    load_key(32'h0080_0000);
    send(8'h41);
    wait_out("t2_wrap", 1'b0, 8'h7A);

    // 3: error passthrough consumes a key step; next key is 8, 'I' -> 'a'
    load_key(32'h0800_0000);
    send(8'h35);
    send(8'h49);
    wait_out("t3_err", 1'b1, 8'h35);
    wait_out("t3_next", 1'b0, 8'h61);
`ifdef VIG_DEC_ERRCNT_EN
    tick();
    chk("t3_err_cnt", {16'd0, err_cnt}, 32'd1);
`endif

    // 4: random stream with random m_ready vs encrypt model
    load_key(32'h1234_5678);
    outq.delete();
    st = 32'h1234_5678;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          int p, c;
          p = $urandom_range(0, 25);
          c = (p + m_key(st)) % 26 + 65;
          st = m_step(st);
          exp_q.push_back(8'(p + 97));
          send(8'(c));
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      begin
        int n = 0;
        while (!done && n < 5000) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
          n++;
        end
        m_ready = 1'b1;
      end
    join
    repeat (10) tick();
    chk("t4_count", outq.size(), 32'd64);
    for (int i = 0; i < 64; i++) begin
      if (outq.size() > 0 && exp_q.size() > 0)
        chk($sformatf("t4_b%0d", i), {23'd0, outq.pop_front()}, {24'd0, exp_q.pop_front()});
    end

    // 5: key_load with a full, stalled pipeline and s_valid high
    load_key(32'h0000_0001);
    m_ready = 1'b0;
    send(8'h41);
    send(8'h42);
    s_valid = 1'b1; s_data = 8'h51;
    key_load = 1'b1; key_seed = 32'h0800_0000; #1;
    chk("t5_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    key_load = 1'b0;
    chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
`ifdef VIG_DEC_ERRCNT_EN
    chk("t5_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    outq.delete();
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    wait_out("t5_new_key", 1'b0, 8'h61);
    tick();
    chk("t5_no_extra", outq.size(), 32'd0);

    // 6: reset mid-stream; keystream restarts from SEED (k=25, 'Z' -> 'a')
    load_key(32'h0800_0000);
    s_valid = 1'b1; s_data = 8'h42;
    tick(); tick();
    rst = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_m_data", {24'd0, m_data}, 32'd0);
    chk("t6_m_err", {31'd0, m_err}, 32'd0);
    chk("t6_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    tick();
    outq.delete();
    send(8'h5A);
    wait_out("t6_seed_key", 1'b0, 8'h61);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
